// File: rtl/ann_pkg.sv
// Shared types and constants for the neural-network datapath stages.
package ann_pkg;

    localparam int unsigned FRAC_BITS   = 6;
    localparam int unsigned ROUND_CONST = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        FIN   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Accumulator width that cannot overflow for up to 2^feature_wide products.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned feature_wide);
        return 2 * data_w + feature_wide + 1;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Registered signed DATA_W x DATA_W multiplier with load enable.
module mac_mult #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);

    localparam int unsigned P_W = 2 * DATA_W;

    // Product register loads only on enabled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= P_W'(a) * P_W'(b);
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate with bias and round-half-up, feeding the activation block.
module neuron_mac
    import ann_pkg::*;
#(
    parameter int unsigned FEATURE_WIDE = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned N_IN         = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic signed [15:0]             bias,
    input  logic                           feat_valid,
    input  logic signed [DATA_W-1:0]       feat_data,
    input  logic signed [DATA_W-1:0]       w_data,
    output logic                           feat_ready,
    output logic                           mac_en,
    output logic                           en,
    output logic signed [FEATURE_WIDE+15:0] out_data,
    input  logic                           act_done,
    output logic                           busy
);

    localparam int unsigned ACC_W = acc_width(DATA_W, FEATURE_WIDE);
    localparam int unsigned OUT_W = FEATURE_WIDE + 16;
    localparam int unsigned CNT_W = FEATURE_WIDE + 1;
    localparam int unsigned P_W   = 2 * DATA_W;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [15:0]        bias_q;
    logic                      p_vld_q;
    logic signed [P_W-1:0]     prod_r;
    logic                      beat;
    logic signed [ACC_W-1:0]   rnd;
    logic signed [ACC_W-1:0]   shf;
    logic signed [OUT_W-1:0]   res;

    assign beat = feat_valid && feat_ready;

    mac_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (beat),
        .a     (feat_data),
        .b     (w_data),
        .p     (prod_r)
    );

    // Next-state, beat counter and rounded pre-activation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rnd     = acc_q + ACC_W'(ROUND_CONST);
        shf     = rnd >>> FRAC_BITS;
        res     = OUT_W'(shf) + OUT_W'(bias_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    count_d = '0;
                end
            end
            ACC: begin
                if (beat) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(N_IN - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = FIN;
            FIN:     state_d = HOLD;
            HOLD: begin
                if (act_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            bias_q     <= '0;
            p_vld_q    <= 1'b0;
            out_data   <= '0;
            feat_ready <= 1'b0;
            mac_en     <= 1'b0;
            en         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_vld_q <= beat;
            if (state_q == IDLE && start) begin
                bias_q <= bias;
                acc_q  <= '0;
            end else if (p_vld_q) begin
                acc_q <= acc_q + ACC_W'(prod_r);
            end
            if (state_q == FIN) begin
                out_data <= res;
            end
            feat_ready <= (state_d == ACC) && (count_d < CNT_W'(N_IN));
            mac_en     <= (state_d == ACC) || (state_d == DRAIN) || (state_d == FIN);
            en         <= (state_d == HOLD);
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac with N_IN=4.
module tb_neuron_mac;

    localparam int unsigned FEATURE_WIDE = 4;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned N_IN         = 4;

    logic                           clk;
    logic                           rst_n;
    logic                           start;
    logic signed [15:0]             bias;
    logic                           feat_valid;
    logic signed [DATA_W-1:0]       feat_data;
    logic signed [DATA_W-1:0]       w_data;
    logic                           feat_ready;
    logic                           mac_en;
    logic                           en;
    logic signed [FEATURE_WIDE+15:0] out_data;
    logic                           act_done;
    logic                           busy;

    int n_chk;
    int n_fail;
    int fa[4];
    int wa[4];

    neuron_mac #(
        .FEATURE_WIDE (FEATURE_WIDE),
        .DATA_W       (DATA_W),
        .N_IN         (N_IN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bias       (bias),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
        .w_data     (w_data),
        .feat_ready (feat_ready),
        .mac_en     (mac_en),
        .en         (en),
        .out_data   (out_data),
        .act_done   (act_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, feat_ready, 0);
        check({tag, "_macen"}, mac_en, 0);
        check({tag, "_en"}, en, 0);
        check({tag, "_out"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One neuron from start through release, with an ignored overrun beat and start in HOLD.
    task automatic run_neuron(input string tag, input int b, input int gap, input int exp);
        start = 1'b1;
        bias  = 16'(b);
        tick();
        start = 1'b0;
        check({tag, "_busy0"}, busy, 1);
        check({tag, "_ready0"}, feat_ready, 1);
        check({tag, "_macen0"}, mac_en, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    feat_valid = 1'b0;
                    feat_data  = 8'sd99;
                    w_data     = 8'sd99;
                    tick();
                    check({tag, "_gap_ready"}, feat_ready, 1);
                end
            end
            feat_valid = 1'b1;
            feat_data  = 8'(fa[i]);
            w_data     = 8'(wa[i]);
            tick();
        end
        feat_valid = 1'b1;
        feat_data  = 8'sd127;
        w_data     = 8'sd127;
        check({tag, "_drain_ready"}, feat_ready, 0);
        check({tag, "_drain_macen"}, mac_en, 1);
        check({tag, "_drain_en"}, en, 0);
        tick();
        feat_valid = 1'b0;
        check({tag, "_fin_en"}, en, 0);
        check({tag, "_fin_macen"}, mac_en, 1);
        tick();
        check({tag, "_hold_en"}, en, 1);
        check({tag, "_hold_macen"}, mac_en, 0);
        check({tag, "_out"}, out_data, exp);
        check({tag, "_hold_busy"}, busy, 1);
        for (int h = 0; h < 10; h++) begin
            tick();
            check({tag, "_held_en"}, en, 1);
            check({tag, "_held_out"}, out_data, exp);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_ign_start_en"}, en, 1);
        check({tag, "_ign_start_busy"}, busy, 1);
        act_done = 1'b1;
        start    = 1'b1;
        tick();
        act_done = 1'b0;
        start    = 1'b0;
        check({tag, "_rel_en"}, en, 0);
        check({tag, "_rel_busy"}, busy, 0);
        check({tag, "_rel_out"}, out_data, exp);
        tick();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_ready"}, feat_ready, 0);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        bias       = '0;
        feat_valid = 1'b0;
        feat_data  = '0;
        w_data     = '0;
        act_done   = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        fa = '{64, 64, 64, 64};
        wa = '{64, 64, 64, 64};
        run_neuron("pos", 0, 0, 256);

        wa = '{-64, -64, -64, -64};
        run_neuron("neg", 32, 0, -224);

        fa = '{1, 0, 0, 0};
        wa = '{32, 0, 0, 0};
        run_neuron("rndA", 0, 0, 1);
        wa = '{-32, 0, 0, 0};
        run_neuron("rndB", 0, 0, 0);
        wa = '{-33, 0, 0, 0};
        run_neuron("rndC", 0, 0, -1);

        fa = '{64, 64, 64, 64};
        wa = '{64, 64, 64, 64};
        run_neuron("gaps", 0, 2, 256);

        // Abort a neuron after two beats; nothing of it may survive.
        start = 1'b1;
        bias  = 16'sd100;
        tick();
        start = 1'b0;
        feat_valid = 1'b1;
        feat_data  = 8'sd127;
        w_data     = 8'sd127;
        tick();
        tick();
        feat_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check_zero("midrst");
        rst_n = 1'b1;
        tick();
        run_neuron("postrst", 0, 0, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
